// File: rtl/pb_debounce.sv
// Mode push-button front end: two-flop synchronizer plus a stable-time FSM that
// gives a debounced pressed level and registered press, release and long-press pulses.
module pb_debounce #(
  parameter int DB_CYCLES   = 50000,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB_n,
  output logic tgglMd,
  output logic press_pls,
  output logic rel_pls,
  output logic long_pls
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_PRE  = HW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic           s1_r, s2_r;
  state_t         state_r, state_s;
  logic [DBW-1:0] db_cnt_r, db_cnt_s;
  logic [HW-1:0]  hold_cnt_r, hold_cnt_s;
  logic           tggl_r, tggl_s;
  logic           press_r, press_s;
  logic           rel_r, rel_s;
  logic           long_r, long_s;

  // Two-flop synchronizer; reset value is the released level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= PB_n;
      s2_r <= s1_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      db_cnt_r   <= {DBW{1'b0}};
      hold_cnt_r <= {HW{1'b0}};
      tggl_r     <= 1'b0;
      press_r    <= 1'b0;
      rel_r      <= 1'b0;
      long_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      db_cnt_r   <= db_cnt_s;
      hold_cnt_r <= hold_cnt_s;
      tggl_r     <= tggl_s;
      press_r    <= press_s;
      rel_r      <= rel_s;
      long_r     <= long_s;
    end
  end

  // Next-state logic; pulses are decoded from the transition so they line up with tgglMd.
  always_comb begin
    state_s    = state_r;
    db_cnt_s   = db_cnt_r;
    hold_cnt_s = hold_cnt_r;
    press_s    = 1'b0;
    rel_s      = 1'b0;
    long_s     = 1'b0;
    case (state_r)
      IDLE: begin
        db_cnt_s = {DBW{1'b0}};
        if (!s2_r) begin
          state_s = PRESS_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (s2_r) begin
          state_s  = IDLE;
          db_cnt_s = {DBW{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
          state_s    = PRESSED;
          db_cnt_s   = {DBW{1'b0}};
          hold_cnt_s = {HW{1'b0}};
          press_s    = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + DBW'(1);
        end
      end
      PRESSED: begin
        db_cnt_s = {DBW{1'b0}};
        if (s2_r) begin
          state_s = RELEASE_WAIT;
        end else if (hold_cnt_r != HOLD_LAST) begin
          // Saturating hold count means the long pulse can fire only once per press.
          hold_cnt_s = hold_cnt_r + HW'(1);
          long_s     = (hold_cnt_r == HOLD_PRE);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      RELEASE_WAIT: begin
        if (!s2_r) begin
          state_s  = PRESSED;
          db_cnt_s = {DBW{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
          state_s  = IDLE;
          db_cnt_s = {DBW{1'b0}};
          rel_s    = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + DBW'(1);
        end
      end
      default: begin
        state_s    = IDLE;
        db_cnt_s   = {DBW{1'b0}};
        hold_cnt_s = {HW{1'b0}};
      end
    endcase
    tggl_s = (state_s == PRESSED) || (state_s == RELEASE_WAIT);
  end

  assign tgglMd    = tggl_r;
  assign press_pls = press_r;
  assign rel_pls   = rel_r;
  assign long_pls  = long_r;

endmodule
